// File: rtl/touch_scan_scheduler_if.sv
// Touchpad controller handshake: one-cycle conversion request out, one-cycle
// done strobe back with the x/y/z sample valid in that same cycle.
interface touch_scan_if;
  logic        scan_start;
  logic        scan_done;
  logic [11:0] x_in;
  logic [11:0] y_in;
  logic [11:0] z_in;

  modport master (output scan_start, input scan_done, x_in, y_in, z_in);
  modport slave  (input scan_start, output scan_done, x_in, y_in, z_in);
endinterface

// File: rtl/touch_scan_scheduler.sv
// Periodic touchpad scan sequencer: requests a conversion every SCAN_PERIOD
// cycles, classifies the sample by pressure and debounces it into press/release.
module touch_scan_scheduler #(
  parameter int          SCAN_PERIOD = 270000,
  parameter logic [11:0] Z_THRESH    = 12'd200,
  parameter int          DEBOUNCE    = 3,
  parameter int          TIMEOUT     = 4096
) (
  input  logic          cclk,
  input  logic          rst,
  input  logic          enable,
  touch_scan_if.master  tp,
  output logic [11:0]   x_out,
  output logic [11:0]   y_out,
  output logic          touch_valid,
  output logic          press_pulse,
  output logic          release_pulse,
  output logic          sample_valid,
  output logic          timeout_err
);
  localparam int PW = $clog2(SCAN_PERIOD);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int HW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [PW-1:0] PER_MAX = PW'(SCAN_PERIOD - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT - 1);
  localparam logic [HW-1:0] HIT_MAX = HW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_EVAL} state_t;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] z;
  } sample_t;

  state_t        state;
  logic [PW-1:0] per_cnt;
  logic [PW-1:0] per_nxt;
  logic [TW-1:0] to_cnt;
  logic [HW-1:0] hit_cnt;
  sample_t       cap;
  logic          start_q;
  logic          touched;

  assign tp.scan_start = start_q;
  assign touched       = (cap.z >= Z_THRESH);

  // Period counter saturates so a long scan just delays the next START.
  always_comb begin
    per_nxt = per_cnt;
    if (per_cnt != PER_MAX) per_nxt = per_cnt + 1'b1;
  end

  always_ff @(posedge cclk) begin
    if (rst) begin
      state         <= S_IDLE;
      per_cnt       <= '0;
      to_cnt        <= '0;
      hit_cnt       <= '0;
      cap           <= '0;
      start_q       <= 1'b0;
      x_out         <= '0;
      y_out         <= '0;
      touch_valid   <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      sample_valid  <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      start_q       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      sample_valid  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!enable) begin
            per_cnt <= '0;
          end else if (per_cnt == PER_MAX) begin
            // per_cnt reads 0 during START so spacing is exactly SCAN_PERIOD
            state   <= S_START;
            start_q <= 1'b1;
            per_cnt <= '0;
          end else begin
            per_cnt <= per_nxt;
          end
        end
        S_START: begin
          per_cnt <= per_nxt;
          to_cnt  <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          per_cnt <= per_nxt;
          if (tp.scan_done) begin
            cap   <= '{x: tp.x_in, y: tp.y_in, z: tp.z_in};
            state <= S_EVAL;
          end else if (to_cnt == TO_MAX) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_EVAL: begin
          per_cnt      <= per_nxt;
          sample_valid <= 1'b1;
          state        <= S_IDLE;
          if (touched) begin
            x_out <= cap.x;
            y_out <= cap.y;
          end
          if (touched != touch_valid) begin
            if (hit_cnt == HIT_MAX) begin
              touch_valid   <= touched;
              hit_cnt       <= '0;
              press_pulse   <= touched;
              release_pulse <= ~touched;
            end else begin
              hit_cnt <= hit_cnt + 1'b1;
            end
          end else begin
            hit_cnt <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/touch_scan_scheduler.md
# touch_scan_scheduler

Sequences the resistive-touchpad ADC front end for the Morse-code IM key input. It issues periodic conversion requests to the touchpad controller and captures the returned x/y/z sample. It classifies each sample as touched or untouched against a pressure threshold and debounces the result into press/release events for the Morse timing logic. It sits between the touchpad controller (`char` start strobe in, x/y/z out) and the dot/dash classifier.

## Interface
Parameters:
- SCAN_PERIOD, 270000: cclk cycles between consecutive scan_start pulses (100 Hz at 27 MHz); must be ≥ 4.
- Z_THRESH, 12'd200: a sample counts as touched when z_in ≥ Z_THRESH (unsigned).
- DEBOUNCE, 3: consecutive agreeing samples required to change touch_valid; must be ≥ 1.
- TIMEOUT, 4096: max cycles to wait for scan_done after scan_start.

Ports:
- cclk  in  1  system clock; one clock domain.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  scanning enable.
- scan_start  out  1  one-cycle conversion request; drives touchpad controller `char`.
- scan_done  in  1  one-cycle pulse; x_in/y_in/z_in valid in the same cycle.
- x_in, y_in, z_in  in  12 each  raw sample from the touchpad controller.
- x_out, y_out  out  12 each  last touched-sample coordinates.
- touch_valid  out  1  debounced touch level.
- press_pulse  out  1  one cycle on the 0→1 transition of touch_valid.
- release_pulse  out  1  one cycle on the 1→0 transition of touch_valid.
- sample_valid  out  1  one cycle per completed, non-timed-out scan.
- timeout_err  out  1  sticky; set on any scan timeout.

## Operation
- FSM states and transitions:
  - IDLE: go to START when enable=1 and per_cnt == SCAN_PERIOD-1.
  - START: scan_start=1 for exactly this cycle; go to WAIT.
  - WAIT: on scan_done, capture x/y/z into internal registers and go to EVAL. Otherwise, when to_cnt == TIMEOUT-1, set timeout_err and go to IDLE.
  - EVAL: one cycle; update debounce and outputs; go to IDLE.
- per_cnt:
  - Cleared in START.
  - Increments in every other state, saturating at SCAN_PERIOD-1.
  - Held at 0 while enable=0 and state=IDLE.
  - Scans never overlap: if the period elapses during WAIT, the next START occurs in the cycle after the FSM returns to IDLE.
- to_cnt: cleared in START; increments in WAIT.
- enable=0 mid-scan (START/WAIT/EVAL): the current scan completes normally; the FSM then parks in IDLE.
- Debounce, evaluated in EVAL with t = (z_cap ≥ Z_THRESH):
  - t ≠ touch_valid: hit_cnt increments. When hit_cnt reaches DEBOUNCE-1 before the increment, touch_valid toggles, hit_cnt clears, and press_pulse (new value 1) or release_pulse (new value 0) fires.
  - t == touch_valid: hit_cnt clears.
- x_out/y_out load x_cap/y_cap on every EVAL with t=1, regardless of debounce state. They hold otherwise.
- A timed-out scan leaves hit_cnt, touch_valid, x_out and y_out unchanged.
- scan_done outside WAIT is ignored.
- If scan_done arrives in the same cycle as the timeout condition, scan_done wins: no error, go to EVAL.
- rst clears all state, regardless of FSM state.

## Timing
- Reset values:
  - state IDLE; all counters 0.
  - scan_start=0, touch_valid=0, press_pulse=0, release_pulse=0, sample_valid=0, timeout_err=0.
  - x_out=0, y_out=0.
- First scan_start is high SCAN_PERIOD cycles after rst deasserts, given enable=1 throughout.
- Steady-state scan_start spacing is exactly SCAN_PERIOD cycles when each scan completes within SCAN_PERIOD-3 cycles.
- scan_done high in cycle n → EVAL in cycle n+1 → sample_valid, press_pulse/release_pulse and the updated touch_valid/x_out/y_out visible in cycle n+2.
- All outputs are registered; press/release/sample_valid/scan_start are exactly one cycle wide.
- timeout_err rises TIMEOUT+1 cycles after scan_start; only rst clears it.

## Test plan
Bench parameters: SCAN_PERIOD=16, Z_THRESH=200, DEBOUNCE=3, TIMEOUT=8.
- Reset/period: rst for 2 cycles, enable=1, model answers scan_done 3 cycles after each scan_start → first scan_start 16 cycles after rst low, then every 16 cycles; all outputs 0 until first sample_valid.
- Press debounce: z=500, x=0x123, y=0x456 on three scans → press_pulse and touch_valid=1 two cycles after the 3rd scan_done; x_out=0x123 after the 1st.
- Glitch rejection: while touched, z=100, z=100, z=500, then z=100 ×3 → no release on the first pair; release_pulse after the 3rd consecutive low sample only.
- Timeout: model never answers → timeout_err=1 nine cycles after scan_start, no sample_valid, next scan_start still issued. A late scan_done while in IDLE is ignored.
- Simultaneity/boundary: scan_done on the same cycle as timeout expiry → sample_valid, timeout_err stays 0. z=200 exactly counts as touched; z=199 does not.
- Enable/reset mid-scan: drop enable in WAIT → the scan completes, then no further scan_start. Assert rst in WAIT → all outputs 0 next cycle and the period restarts from 0.
